serial_cmd_master: RTL and testbench

Master-side sequencer for the 42-bit serial register-access link whose slave end is a 42-stage shift register clocked by `sclk`, framed by `en`, fed by `sda`. Two requesters are served round-robin, each access is serialised as one frame (addr[7:0], rw, data[31:0], end-marker t), and for reads the 32-bit response is captured from `sdi`. It sits in the trigger FPGA between the local control logic and the TDC/readout board serial port.

---
 rtl/serial_cmd_master.sv | 235 +++++++++++++++++++++++
 tb/tb_serial_cmd_master.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_cmd_master.sv
// rtl/serial_cmd_master.sv - round-robin two-requester master for the 42-bit serial register link
// Optional feature macro: SERIAL_READBACK_EN (adds the READ state and sdi capture into rdata).
module serial_cmd_master #(
  parameter int CLK_DIV  = 2,
  parameter int GAP_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        rw0,
  input  logic        rw1,
  input  logic [7:0]  addr0,
  input  logic [7:0]  addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        sclk,
  output logic        en,
  output logic        sda,
  input  logic        sdi
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    GAP   = 3'd3,
    READ  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [5:0] GAP_LAST   = 6'(GAP_BITS - 1);
  localparam logic [5:0] FRAME_LAST = 6'd41;
  localparam logic [5:0] READ_LAST  = 6'd31;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;   // 0 = requester 0, 1 = requester 1
  logic        last_q,  last_d;    // requester granted most recently
  logic        rd_q,    rd_d;      // captured access is a read
  logic [41:0] frame_q, frame_d;
  logic [5:0]  bit_q,   bit_d;
  logic [7:0]  div_q,   div_d;
  logic        phase_q, phase_d;   // 0 = sclk low half, 1 = sclk high half

  logic half_done;
  logic bit_end;
  logic timing_active;

  // A half period ends on the last divider count; a bit ends after the high half.
  assign half_done     = (div_q == DIV_LAST);
  assign bit_end       = half_done && phase_q;
  assign timing_active = (state_q == SHIFT) || (state_q == GAP) || (state_q == READ);

`ifdef SERIAL_READBACK_EN
  logic [31:0] rx_q,    rx_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rise;

  // sclk rises on the edge that ends the low half of a bit period
  assign rise = half_done && !phase_q;

  // Read-back shifter and result register
  always_comb begin
    rx_d    = rx_q;
    rdata_d = rdata_q;
    if (state_q == LOAD) begin
      rx_d = 32'h0;
    end else if (state_q == READ && rise) begin
      rx_d = {rx_q[30:0], sdi};
    end
    if (state_q == DONE && rd_q) begin
      rdata_d = rx_q;
    end
  end

  // Read-back state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q    <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
`else
  logic unused_sdi;

  assign unused_sdi = sdi;
  assign rdata      = 32'h0;
`endif

  // Next-state logic: arbitration, frame build, bit timing and sequencing
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    rd_d    = rd_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    div_d   = div_q;
    phase_d = phase_q;

    if (timing_active) begin
      if (half_done) begin
        div_d   = 8'd0;
        phase_d = ~phase_q;
      end else begin
        div_d = div_q + 8'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          grant_d = ~last_q;
          state_d = LOAD;
        end else if (req0) begin
          grant_d = 1'b0;
          state_d = LOAD;
        end else if (req1) begin
          grant_d = 1'b1;
          state_d = LOAD;
        end
      end

      LOAD: begin
        if (grant_q) begin
          rd_d    = ~rw1;
          frame_d = {addr1, rw1, (rw1 ? wdata1 : 32'h0), 1'b1};
        end else begin
          rd_d    = ~rw0;
          frame_d = {addr0, rw0, (rw0 ? wdata0 : 32'h0), 1'b1};
        end
        bit_d   = 6'd0;
        div_d   = 8'd0;
        phase_d = 1'b0;
        state_d = SHIFT;
      end

      SHIFT: begin
        if (bit_end) begin
          if (bit_q == FRAME_LAST) begin
            bit_d   = 6'd0;
            state_d = GAP;
          end else begin
            bit_d   = bit_q + 6'd1;
            frame_d = {frame_q[40:0], 1'b0};
          end
        end
      end

      GAP: begin
        if (bit_end) begin
          bit_d = 6'd0;
          if (bit_q == GAP_LAST) begin
`ifdef SERIAL_READBACK_EN
            state_d = rd_q ? READ : DONE;
`else
            state_d = DONE;
`endif
          end else begin
            bit_d = bit_q + 6'd1;
          end
        end
      end

`ifdef SERIAL_READBACK_EN
      READ: begin
        if (bit_end) begin
          if (bit_q == READ_LAST) begin
            bit_d   = 6'd0;
            state_d = DONE;
          end else begin
            bit_d = bit_q + 6'd1;
          end
        end
      end
`endif

      DONE: begin
        last_d  = grant_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      rd_q    <= 1'b0;
      frame_q <= 42'h0;
      bit_q   <= 6'd0;
      div_q   <= 8'd0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      frame_q <= frame_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end

  // Link and handshake outputs decoded from registered state only
  assign en   = (state_q == SHIFT);
  assign sda  = (state_q == SHIFT) && frame_q[41];
  assign sclk = ((state_q == SHIFT) || (state_q == READ)) && phase_q;
  assign busy = (state_q != IDLE);
  assign ack0 = (state_q == DONE) && !grant_q;
  assign ack1 = (state_q == DONE) &&  grant_q;

`ifndef SERIAL_READBACK_EN
  logic [5:0] unused_read_last;
  assign unused_read_last = READ_LAST;
`endif

endmodule

// File: tb/tb_serial_cmd_master.sv
// tb/tb_serial_cmd_master.sv - directed table-driven bench for serial_cmd_master
module tb_serial_cmd_master;

`ifdef SERIAL_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam int WR_LAT = 178;
  localparam int RD_LAT = RB ? 306 : 178;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0, req1, rw0, rw1;
  logic [7:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1, busy, sclk, en, sda, sdi;
  logic [31:0] rdata;

  logic        b_req, b_ack0, b_ack1, b_busy, b_sclk, b_en, b_sda;
  logic [31:0] b_rdata;

  int checks = 0;
  int failures = 0;

  serial_cmd_master #(.CLK_DIV(2), .GAP_BITS(2)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .sclk(sclk), .en(en), .sda(sda), .sdi(sdi)
  );

  serial_cmd_master #(.CLK_DIV(1), .GAP_BITS(4)) u_d1 (
    .clk(clk), .rst(rst),
    .req0(b_req), .req1(1'b0), .rw0(1'b1), .rw1(1'b0),
    .addr0(8'hC3), .addr1(8'h00), .wdata0(32'h0F0F0F0F), .wdata1(32'h0),
    .ack0(b_ack0), .ack1(b_ack1), .rdata(b_rdata), .busy(b_busy),
    .sclk(b_sclk), .en(b_en), .sda(b_sda), .sdi(1'b0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Slave shift register model and sdi response driver
  logic [41:0] shreg;
  int          rises;
  logic [31:0] resp;
  int          rd_idx;
  always @(posedge sclk) begin
    if (en) begin
      shreg = {shreg[40:0], sda};
      rises++;
    end else begin
      sdi = (rd_idx >= 0) ? resp[rd_idx] : 1'b0;
      rd_idx--;
    end
  end

  logic [41:0] b_shreg;
  int          b_rises;
  always @(posedge b_sclk) begin
    if (b_en) begin
      b_shreg = {b_shreg[40:0], b_sda};
      b_rises++;
    end
  end

  int both_acks = 0;
  always @(negedge clk) if (ack0 && ack1) both_acks++;

  typedef struct {
    logic        who;
    logic        rw;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rsp;
    int          lat;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic set_req(input logic who, input logic v, input logic rw,
                         input logic [7:0] a, input logic [31:0] wd);
    if (who == 1'b0) begin
      req0 = v; rw0 = rw; addr0 = a; wdata0 = wd;
    end else begin
      req1 = v; rw1 = rw; addr1 = a; wdata1 = wd;
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int   ack_at;
    logic which;
    logic busy_gap;
    logic en_c1, en_c2, busy_c1;
    logic [31:0] rd_at_ack;
    ack_at = -1; which = 1'b0; busy_gap = 1'b0;
    en_c1 = 1'b1; en_c2 = 1'b0; busy_c1 = 1'b0; rd_at_ack = 32'hx;
    resp = v.rsp; sdi = v.rsp[31]; rd_idx = 30;
    rises = 0; shreg = 42'h0;
    @(negedge clk);
    set_req(v.who, 1'b1, v.rw, v.addr, v.wdata);
    @(posedge clk);
    for (int cnt = 1; cnt <= v.lat + 40; cnt++) begin
      @(negedge clk);
      if (cnt == 1) begin en_c1 = en; busy_c1 = busy; end
      if (cnt == 2) en_c2 = en;
      if (cnt == 3) set_req(v.who, 1'b1, ~v.rw, ~v.addr, ~v.wdata);
      if (ack0 || ack1) begin
        ack_at = cnt; which = ack1; rd_at_ack = rdata;
        set_req(v.who, 1'b0, 1'b0, 8'h0, 32'h0);
        break;
      end
      if (!busy) busy_gap = 1'b1;
    end
    set_req(v.who, 1'b0, 1'b0, 8'h0, 32'h0);
    check({tag, " ack_latency"}, ack_at, v.lat);
    check({tag, " ack_port"}, which, v.who);
    check({tag, " rdata"}, rd_at_ack, v.exp_rd);
    check({tag, " busy_c1"}, busy_c1, 1'b1);
    check({tag, " en_c1"}, en_c1, 1'b0);
    check({tag, " en_c2"}, en_c2, 1'b1);
    check({tag, " busy_hold"}, busy_gap, 1'b0);
    check({tag, " rises"}, rises, 42);
    check({tag, " frame"}, shreg, {v.addr, v.rw, (v.rw ? v.wdata : 32'h0), 1'b1});
    @(negedge clk);
    check({tag, " idle_busy"}, busy, 1'b0);
  endtask

  vec_t vecs[5];
  logic [2:0] grant_seq [3];
  int   nacks;
  int   late_acks;
  int   tog_err;
  int   b_ack_at;
  logic prev_sclk, prev_en;
  logic rst_ok;
  vec_t clean;

  initial begin
    vecs[0] = '{who:1'b0, rw:1'b1, addr:8'hA5, wdata:32'hDEADBEEF, rsp:32'h0,
                lat:WR_LAT, exp_rd:32'h0};
    vecs[1] = '{who:1'b1, rw:1'b0, addr:8'h3C, wdata:32'hCAFEF00D, rsp:32'h12345678,
                lat:RD_LAT, exp_rd:(RB ? 32'h12345678 : 32'h0)};
    vecs[2] = '{who:1'b1, rw:1'b1, addr:8'h00, wdata:32'hFFFFFFFF, rsp:32'h0,
                lat:WR_LAT, exp_rd:(RB ? 32'h12345678 : 32'h0)};
    vecs[3] = '{who:1'b0, rw:1'b0, addr:8'hFF, wdata:32'h55AA55AA, rsp:32'h80000001,
                lat:RD_LAT, exp_rd:(RB ? 32'h80000001 : 32'h0)};
    vecs[4] = '{who:1'b0, rw:1'b1, addr:8'h5A, wdata:32'h00000000, rsp:32'h0,
                lat:WR_LAT, exp_rd:(RB ? 32'h80000001 : 32'h0)};
    clean   = '{who:1'b0, rw:1'b1, addr:8'h81, wdata:32'hA5A5A5A5, rsp:32'h0,
                lat:WR_LAT, exp_rd:32'h0};

    rst = 1'b1; b_req = 1'b0;
    req0 = 0; req1 = 0; rw0 = 0; rw1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    sdi = 1'b0; rd_idx = -1; resp = 32'h0; rises = 0; b_rises = 0;
    shreg = 42'h0; b_shreg = 42'h0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {ack0, ack1, busy, sclk, en, sda}, 6'b0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_b_outputs", {b_ack0, b_ack1, b_busy, b_sclk, b_en, b_sda}, 6'b0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous requests straight after reset: req0, req1, req0
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    set_req(1'b0, 1'b1, 1'b1, 8'h11, 32'h1);
    set_req(1'b1, 1'b1, 1'b1, 8'h22, 32'h2);
    nacks = 0; both_acks = 0;
    for (int c = 0; c < 700 && nacks < 3; c++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        grant_seq[nacks] = {1'b0, ack1, ack0};
        nacks++;
        if (nacks == 3) begin
          set_req(1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
          set_req(1'b1, 1'b0, 1'b0, 8'h0, 32'h0);
        end
      end
    end
    set_req(1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 8'h0, 32'h0);
    check("rr_ack_count", nacks, 3);
    check("rr_first", grant_seq[0], 3'b001);
    check("rr_second", grant_seq[1], 3'b010);
    check("rr_third", grant_seq[2], 3'b001);
    check("rr_double_ack", both_acks, 0);
    repeat (2) @(negedge clk);

    // Reset in the middle of the frame
    rises = 0;
    set_req(1'b0, 1'b1, 1'b1, 8'hE7, 32'h13572468);
    for (int c = 0; c < 400 && rises < 21; c++) @(negedge clk);
    check("midrst_reached_bit20", rises, 21);
    #2 rst = 1'b1;
    #1 check("midrst_outputs", {en, sclk, sda, busy, ack0, ack1}, 6'b0);
    set_req(1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    late_acks = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ack0 || ack1 || busy) late_acks++;
    end
    check("midrst_no_ack", late_acks, 0);
    run_txn(clean, "post_rst");

    // CLK_DIV=1, GAP_BITS=4 instance
    b_ack_at = -1; tog_err = 0; b_rises = 0; b_shreg = 42'h0;
    prev_sclk = 1'b0; prev_en = 1'b0;
    @(negedge clk); b_req = 1'b1;
    @(posedge clk);
    for (int cnt = 1; cnt <= 140; cnt++) begin
      @(negedge clk);
      if (b_en && prev_en && (b_sclk == prev_sclk)) tog_err++;
      prev_sclk = b_sclk; prev_en = b_en;
      if (b_ack0) begin b_ack_at = cnt; b_req = 1'b0; break; end
    end
    b_req = 1'b0;
    check("div1_ack_latency", b_ack_at, 94);
    check("div1_toggle", tog_err, 0);
    check("div1_rises", b_rises, 42);
    check("div1_frame", b_shreg, {8'hC3, 1'b1, 32'h0F0F0F0F, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
